flag_word_builder: RTL and testbench
====================================

// Module: flag_word_builder
// PURPOSE
//  Producer side of the flag-word interface: builds a WIDTH-bit flag word by
//  setting bits at indices received over a valid/ready input stream.
//  On the index tagged "last", it hands the finished word to a downstream
//  first-set-bit scanner over a valid/ready output.
//  Sits between event sources (which report bit positions) and the flag consumer.
// PARAMETERS
//  WIDTH  16  flag word width in bits
//  IDX_W  4   index width; must equal $clog2(WIDTH)
//  CNT_W  5   popcount width; must equal $clog2(WIDTH+1)
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      in_idx/in_last are valid
//  in_ready   out  1      block can accept an index
//  in_idx     in   IDX_W  bit position to set
//  in_last    in   1      this index closes the current word
//  out_valid  out  1      out_flag/out_count are valid
//  out_ready  in   1      consumer takes the word
//  out_flag   out  WIDTH  completed flag word
//  out_count  out  CNT_W  number of distinct bits set in out_flag
//  dup_err    out  1      present only with FLAG_DUP_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (async assert, sync deassert at the next edge):
//   - state=COLLECT, flag=0, count=0.
//   - Outputs: in_ready=1, out_valid=0, out_flag=0, out_count=0, dup_err=0.
//  FSM: two states, COLLECT and EMIT.
//   - in_ready = (state==COLLECT); out_valid = (state==EMIT). Both are decoded
//     from registered state, so there is no comb path from in_* to out_*.
//  COLLECT:
//   - Accept on in_valid&in_ready: flag[in_idx]<=1.
//   - count increments only when that bit was previously 0. Duplicates merge
//     and are not double-counted.
//   - in_idx>=WIDTH (non-power-of-2 WIDTH): no bit set, no count change.
//     in_last is still honoured.
//   - Accept with in_last=1 -> EMIT. That same index is included in the word.
//  EMIT:
//   - Latency: out_valid rises on the first edge after the last index is accepted.
//   - out_flag and out_count are held stable while out_valid=1 and out_ready=0.
//   - in_ready=0, so inputs are ignored.
//   - On out_valid&out_ready: flag<=0, count<=0, return to COLLECT.
//     in_ready=1 on the following cycle. Gap between words is one cycle minimum.
//   - out_ready asserted before out_valid has no effect.
//  Count saturation is not possible (count<=WIDTH fits CNT_W). No wrap-around.
//  Reset during COLLECT or EMIT discards the partial or pending word immediately.
//  A word with no in-range index emits out_flag=0, out_count=0.
// CONFIGURATION
//  FLAG_DUP_ERR_EN defined:
//   - dup_err port exists. It is a registered 1-cycle pulse, the cycle after
//     accepting an in-range in_idx whose bit was already set.
//   - It pulses once per duplicate. Word content is unaffected.
//  FLAG_DUP_ERR_EN undefined:
//   - dup_err port and logic are absent; duplicates merge silently.
// TESTING
//  1. Hold reset_n=0 -> in_ready=1, out_valid=0, out_flag=16'h0000, out_count=0.
//  2. Send idx=13 with last=1 -> next cycle out_valid=1, out_flag=16'h2000,
//     out_count=1. Downstream scanner reports bit 13.
//  3. Send idx 0, 5, 15(last) back-to-back -> out_flag=16'h8021, out_count=3.
//     out_valid rises 1 cycle after idx 15 is accepted.
//  4. Word 16'h8021 with out_ready=0 for 5 cycles -> out_flag held, in_ready=0,
//     in_valid ignored. Then out_ready=1 -> word consumed; next cycle
//     in_ready=1, flag=0.
//  5. Send idx 3, 3, 3(last) -> out_flag=16'h0008, out_count=1. With
//     FLAG_DUP_ERR_EN, dup_err pulses exactly twice; without it, no port.
//  6. Pull reset_n low mid-EMIT, asynchronously between edges -> out_valid=0
//     and out_flag=0 before the next edge. After release, idx 7 with last
//     -> 16'h0080, count 1.

Source files
------------

// File: rtl/flag_word_builder.sv
// Purpose: collects bit indices from a valid/ready stream into a WIDTH-bit flag word and hands it downstream on "last".
// Latency: out_valid rises on the first edge after the last index is accepted; one idle cycle minimum between words.
// Backpressure: word held stable while out_ready=0; in_ready=0 during EMIT. Optional dup_err port under FLAG_DUP_ERR_EN.
module flag_word_builder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_flag,
  output logic [CNT_W-1:0] out_count
`ifdef FLAG_DUP_ERR_EN
  ,
  output logic             dup_err
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // One extra bit so WIDTH itself is representable for the range compare.
  localparam logic [IDX_W:0]   WIDTH_L = WIDTH[IDX_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] flag;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             drain;
  logic             in_range;
  logic             bit_was_set;

  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign in_range = ({1'b0, in_idx} < WIDTH_L);

  // Current value of the addressed bit; out-of-range indices read as clear.
  always_comb begin
    bit_was_set = 1'b0;
    if (in_range) begin
      bit_was_set = flag[in_idx];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; both handshakes come from registered state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Word accumulation: set the addressed bit, count only newly set bits, clear on drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag  <= '0;
      count <= '0;
    end else if (drain) begin
      flag  <= '0;
      count <= '0;
    end else if (accept && in_range && !bit_was_set) begin
      flag[in_idx] <= 1'b1;
      count        <= count + CNT_ONE;
    end
  end

`ifdef FLAG_DUP_ERR_EN
  // One-cycle pulse after accepting an in-range index whose bit was already set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dup_err <= 1'b0;
    end else begin
      dup_err <= accept & in_range & bit_was_set;
    end
  end
`endif

  assign out_flag  = flag;
  assign out_count = count;

endmodule

// File: tb/tb_flag_word_builder.sv
module tb_flag_word_builder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_idx;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_flag;
  logic [4:0]  out_count;
`ifdef FLAG_DUP_ERR_EN
  logic        dup_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  flag_word_builder #(
    .WIDTH(16),
    .IDX_W(4),
    .CNT_W(5)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_flag (out_flag),
    .out_count(out_count)
`ifdef FLAG_DUP_ERR_EN
    ,
    .dup_err  (dup_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one index for exactly one edge (caller ensures in_ready=1).
  task automatic send(input logic [3:0] idx, input logic last);
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bounded wait for in_ready; an expired budget counts as a failure.
  task automatic wait_in_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // 1. Reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flag",  32'(out_flag),  32'h0000);
    check("rst_out_count", 32'(out_count), 32'd0);
`ifdef FLAG_DUP_ERR_EN
    check("rst_dup_err",   32'(dup_err),   32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // 2. Single index with last
    wait_in_ready("t2_ready");
    send(4'd13, 1'b1);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_flag",  32'(out_flag),  32'h2000);
    check("t2_out_count", 32'(out_count), 32'd1);
    check("t2_in_ready",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_drain_valid", 32'(out_valid), 32'd0);
    check("t2_drain_ready", 32'(in_ready),  32'd1);
    check("t2_drain_flag",  32'(out_flag),  32'h0000);

    // 3. Back-to-back indices 0, 5, 15(last)
    wait_in_ready("t3_ready");
    send(4'd0, 1'b0);
    check("t3_mid_valid", 32'(out_valid), 32'd0);
    check("t3_mid_count", 32'(out_count), 32'd1);
    send(4'd5, 1'b0);
    check("t3_mid2_valid", 32'(out_valid), 32'd0);
    send(4'd15, 1'b1);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_out_flag",  32'(out_flag),  32'h8021);
    check("t3_out_count", 32'(out_count), 32'd3);

    // 4. Stall for 5 cycles with a competing input; word held, input ignored
    in_valid = 1'b1;
    in_idx   = 4'd2;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_flag",  32'(out_flag),  32'h8021);
      check("t4_hold_count", 32'(out_count), 32'd3);
      check("t4_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_drain_valid", 32'(out_valid), 32'd0);
    check("t4_drain_ready", 32'(in_ready),  32'd1);
    check("t4_drain_flag",  32'(out_flag),  32'h0000);
    check("t4_drain_count", 32'(out_count), 32'd0);

    // 5. Duplicates 3, 3, 3(last); out_ready held high early must not drain early
    wait_in_ready("t5_ready");
    out_ready = 1'b1;
    send(4'd3, 1'b0);
`ifdef FLAG_DUP_ERR_EN
    check("t5_dup0", 32'(dup_err), 32'd0);
`endif
    check("t5_early_valid", 32'(out_valid), 32'd0);
    send(4'd3, 1'b0);
`ifdef FLAG_DUP_ERR_EN
    check("t5_dup1", 32'(dup_err), 32'd1);
`endif
    send(4'd3, 1'b1);
`ifdef FLAG_DUP_ERR_EN
    check("t5_dup2", 32'(dup_err), 32'd1);
`endif
    check("t5_out_valid", 32'(out_valid), 32'd1);
    check("t5_out_flag",  32'(out_flag),  32'h0008);
    check("t5_out_count", 32'(out_count), 32'd1);
    tick();
    out_ready = 1'b0;
`ifdef FLAG_DUP_ERR_EN
    check("t5_dup3", 32'(dup_err), 32'd0);
`endif
    check("t5_drain_valid", 32'(out_valid), 32'd0);
    check("t5_drain_ready", 32'(in_ready),  32'd1);

    // 6. Asynchronous reset mid-EMIT
    wait_in_ready("t6_ready");
    send(4'd9, 1'b1);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_flag",  32'(out_flag),  32'h0200);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_flag",  32'(out_flag),  32'h0000);
    check("t6_rst_count", 32'(out_count), 32'd0);
    check("t6_rst_ready", 32'(in_ready),  32'd1);
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    wait_in_ready("t6_post_ready");
    send(4'd7, 1'b1);
    check("t6_post_valid", 32'(out_valid), 32'd1);
    check("t6_post_flag",  32'(out_flag),  32'h0080);
    check("t6_post_count", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_post_drain", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
